// File: rtl/cmp_pkg.sv
// ============================================================================
// Module   : cmp_pkg
// Brief    : Shared types and result encoding for the serial comparator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cmp_pkg;

  // Controller states: waiting, walking bit pairs, one-cycle result strobe.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot result encoding, ordered {great, equal, less}.
  localparam logic [2:0] NONE  = 3'b000;
  localparam logic [2:0] GREAT = 3'b100;
  localparam logic [2:0] EQUAL = 3'b010;
  localparam logic [2:0] LESS  = 3'b001;

  // Map the winner of the first differing bit pair onto the result code.
  function automatic logic [2:0] res_from_win(input logic a_wins);
    return a_wins ? GREAT : LESS;
  endfunction

endpackage : cmp_pkg

`default_nettype wire

// File: rtl/cmp_bit_decide.sv
// ============================================================================
// Module   : cmp_bit_decide
// Brief    : Combinational decision for one bit pair of a serial compare.
//            In signed mode the MSB is the sign bit, so a 1 there is the
//            smaller operand; every other bit is weighted positively.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_bit_decide (
  input  logic a_bit,
  input  logic b_bit,
  input  logic is_msb,
  input  logic signed_mode,
  output logic differ,
  output logic a_wins
);

  logic w_sign_bit;

  assign w_sign_bit = is_msb & signed_mode;
  assign differ     = a_bit ^ b_bit;
  // Only meaningful when differ is set: A wins if it holds the 1, unless
  // that 1 is a sign bit.
  assign a_wins     = differ & (w_sign_bit ? ~a_bit : a_bit);

endmodule : cmp_bit_decide

`default_nettype wire

// File: rtl/cmp_serial.sv
// ============================================================================
// Module   : cmp_serial
// Brief    : Bit-serial magnitude comparator. Captures A/B on start, walks
//            the bit pairs MSB first one per clock, and stops at the first
//            difference (or after bit 0) with a registered one-hot result
//            and a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_serial
  import cmp_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             great,
  output logic             equal,
  output logic             less
);

  localparam int               IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] c_IDX_MSB = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] c_IDX_ONE = IDX_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               signed_q, signed_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]         res_q, res_d;
  logic               done_q, done_d;

  logic               w_a_bit;
  logic               w_b_bit;
  logic               w_is_msb;
  logic               w_differ;
  logic               w_a_wins;

  assign w_a_bit  = a_q[idx_q];
  assign w_b_bit  = b_q[idx_q];
  assign w_is_msb = (idx_q == c_IDX_MSB);

  cmp_bit_decide u_bit_decide (
    .a_bit       (w_a_bit),
    .b_bit       (w_b_bit),
    .is_msb      (w_is_msb),
    .signed_mode (signed_q),
    .differ      (w_differ),
    .a_wins      (w_a_wins)
  );

  // Next-state logic: accept in IDLE/DONE, walk one bit per cycle in CMP.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    idx_d    = idx_q;
    res_d    = res_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          signed_d = signed_mode;
          idx_d    = c_IDX_MSB;
          res_d    = NONE;
          state_d  = CMP;
        end else if (state_q == DONE) begin
          state_d  = IDLE;
        end
      end

      CMP: begin
        if (w_differ) begin
          res_d   = res_from_win(w_a_wins);
          done_d  = 1'b1;
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d   = EQUAL;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q - c_IDX_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      idx_q    <= '0;
      res_q    <= NONE;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
      done_q   <= done_d;
    end
  end

  assign busy  = (state_q == CMP);
  assign done  = done_q;
  assign great = res_q[2];
  assign equal = res_q[1];
  assign less  = res_q[0];

endmodule : cmp_serial

`default_nettype wire

// File: tb/tb_cmp_serial.sv
// ============================================================================
// Module   : tb_cmp_serial
// Brief    : Directed testbench for cmp_serial (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_serial;

  localparam logic [2:0] R_NONE  = 3'b000;
  localparam logic [2:0] R_GREAT = 3'b100;
  localparam logic [2:0] R_EQUAL = 3'b010;
  localparam logic [2:0] R_LESS  = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       signed_mode;
  logic       busy;
  logic       done;
  logic       great;
  logic       equal;
  logic       less;

  int n_cmp = 0;
  int n_err = 0;

  cmp_serial #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .A           (A),
    .B           (B),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .great       (great),
    .equal       (equal),
    .less        (less)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sm;
    logic [2:0] res;
    int         lat;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one comparison and check latency, busy span, result and hold.
  // Called just after a rising edge; returns just after a rising edge in IDLE.
  task automatic run_cmp(input logic [3:0] a, input logic [3:0] b, input logic sm,
                         input logic [2:0] exp_res, input int exp_lat, input string tag);
    int  lat;
    int  busy_cnt;
    bit  got;
    start       = 1'b1;
    A           = a;
    B           = b;
    signed_mode = sm;
    tick();
    start = 1'b0;
    chk({tag, " busy after accept"}, 32'(busy), 32'd1);
    chk({tag, " result cleared"}, 32'({great, equal, less}), 32'(R_NONE));
    busy_cnt = 1;
    got      = 1'b0;
    lat      = 0;
    for (int n = 1; n <= 20; n++) begin
      A           = 4'($urandom);
      B           = 4'($urandom);
      signed_mode = 1'($urandom);
      tick();
      if (done) begin
        got = 1'b1;
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
    end
    chk({tag, " done seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
    chk({tag, " busy low at done"}, 32'(busy), 32'd0);
    chk({tag, " result"}, 32'({great, equal, less}), 32'(exp_res));
    tick();
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
    chk({tag, " result held"}, 32'({great, equal, less}), 32'(exp_res));
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{4'd9,  4'd3,  1'b0, R_GREAT, 1};
    vecs[1]  = '{4'd5,  4'd5,  1'b0, R_EQUAL, 4};
    vecs[2]  = '{4'd9,  4'd3,  1'b1, R_LESS,  1};
    vecs[3]  = '{4'd6,  4'd7,  1'b0, R_LESS,  4};
    vecs[4]  = '{4'd3,  4'd1,  1'b0, R_GREAT, 3};
    vecs[5]  = '{4'd12, 4'd13, 1'b1, R_LESS,  4};
    vecs[6]  = '{4'd15, 4'd0,  1'b1, R_LESS,  1};
    vecs[7]  = '{4'd0,  4'd15, 1'b0, R_LESS,  1};
    vecs[8]  = '{4'd7,  4'd8,  1'b1, R_GREAT, 1};
    vecs[9]  = '{4'd10, 4'd8,  1'b0, R_GREAT, 3};
    vecs[10] = '{4'd0,  4'd0,  1'b1, R_EQUAL, 4};
    vecs[11] = '{4'd5,  4'd4,  1'b1, R_GREAT, 4};

    // Reset held two cycles with start asserted: reset must win.
    rst         = 1'b1;
    start       = 1'b1;
    A           = 4'd9;
    B           = 4'd3;
    signed_mode = 1'b0;
    tick();
    tick();
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", 32'({great, equal, less}), 32'(R_NONE));
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("idle after reset busy", 32'(busy), 32'd0);

    // Table-driven comparisons.
    for (int i = 0; i < 12; i++) begin
      run_cmp(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].res, vecs[i].lat,
              $sformatf("vec%0d", i));
    end

    // Start while busy is ignored; start during DONE is accepted.
    start = 1'b1; A = 4'd6; B = 4'd7; signed_mode = 1'b0;
    tick();                                   // edge 0: accept
    start = 1'b0;
    tick();                                   // edge 1
    start = 1'b1; A = 4'd15; B = 4'd0;
    tick();                                   // edge 2: ignored
    start = 1'b0;
    chk("busy start ignored busy", 32'(busy), 32'd1);
    tick();                                   // edge 3
    chk("busy start no early done", 32'(done), 32'd0);
    tick();                                   // edge 4
    chk("busy start done", 32'(done), 32'd1);
    chk("busy start result", 32'({great, equal, less}), 32'(R_LESS));
    start = 1'b1; A = 4'd2; B = 4'd2;
    tick();                                   // accept during DONE
    start = 1'b0;
    chk("reaccept busy", 32'(busy), 32'd1);
    chk("reaccept cleared", 32'({great, equal, less}), 32'(R_NONE));
    tick(); tick(); tick();
    chk("reaccept no early done", 32'(done), 32'd0);
    tick();
    chk("reaccept done", 32'(done), 32'd1);
    chk("reaccept result", 32'({great, equal, less}), 32'(R_EQUAL));
    tick();

    // Reset mid-operation aborts without a done pulse.
    start = 1'b1; A = 4'd0; B = 4'd1; signed_mode = 1'b0;
    tick();                                   // edge 0: accept
    start = 1'b0;
    tick();                                   // edge 1
    rst = 1'b1;
    tick();                                   // edge 2: reset
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort result", 32'({great, equal, less}), 32'(R_NONE));
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("abort no done", 32'(done), 32'd0);
    end
    run_cmp(4'd3, 4'd1, 1'b0, R_GREAT, 3, "after abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_cmp_serial

`default_nettype wire

// File: doc/cmp_serial.md
CMP_SERIAL -- requirements
Module: cmp_serial

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request a comparison; sampled on each clk edge.
REQ-006 A  input  WIDTH  operand A; sampled only on an accepting start edge.
REQ-007 B  input  WIDTH  operand B; sampled only on an accepting start edge.
REQ-008 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with A/B.
REQ-009 busy  output  1  high while a comparison is in progress.
REQ-010 done  output  1  one-cycle pulse marking a valid result.
REQ-011 great  output  1  registered result, A > B.
REQ-012 equal  output  1  registered result, A == B.
REQ-013 less  output  1  registered result, A < B.

Function
REQ-014 FSM states SHALL be IDLE, CMP and DONE.
REQ-015 Start acceptance: start=1 accepted in IDLE or DONE; ignored in CMP.
REQ-016 On the accepting edge:
- capture A, B and signed_mode
- set bit index to WIDTH-1
- clear great/equal/less to 0
- move to CMP.
REQ-017 CMP behaviour:
- each edge examines one captured bit pair, MSB first
- index decrements by 1 per edge.
REQ-018 Unsigned decision: at the first differing bit, A bit = 1 gives great, otherwise less.
REQ-019 Signed decision:
- difference at bit WIDTH-1: A bit = 1 gives less, otherwise great
- difference at any lower bit: same rule as unsigned.
REQ-020 Terminate on the edge that finds a difference; do not examine remaining bits.
REQ-021 If index 0 is examined and all bits are equal, set equal=1.
REQ-022 On the terminating edge:
- set exactly one of great/equal/less
- set done=1
- move to DONE.
REQ-023 Latency: done is high min(k+1, WIDTH) edges after the accepting edge, where k = number of leading equal bit pairs.
REQ-024 DONE lasts exactly one cycle. With no start it returns to IDLE; with start it re-enters CMP per REQ-016.
REQ-025 Result hold: great/equal/less SHALL hold until the next accepting edge or reset; they are one-hot or all-zero at all times.
REQ-026 busy SHALL be 1 exactly while state is CMP.
REQ-027 A and B changing while busy SHALL have no effect on the result.

Reset
REQ-028 When rst=1 at an edge:
- state goes to IDLE
- busy, done, great, equal and less all go to 0
- captured operands and index are cleared.
REQ-029 rst has priority over start.
REQ-030 Reset during CMP SHALL abort with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Structure
REQ-031 Shared package cmp_pkg SHALL hold the state enumeration (IDLE/CMP/DONE) and the result encoding constants (GREAT/EQUAL/LESS).
REQ-032 One sub-module, cmp_bit_decide, SHALL be combinational, taking a bit, b bit, is_msb and signed_mode, and returning differ and a_wins.
REQ-033 WIDTH-dependent widths (index counter = $clog2(WIDTH)) SHALL be derived locally, not placed in the package.

Verification (WIDTH=4)
REQ-034 Reset: hold rst 2 cycles with start=1 -> busy=done=great=equal=less=0, state IDLE.
REQ-035 Unsigned MSB difference: A=9, B=3, signed_mode=0 -> great=1, done 1 edge after start, busy high 1 cycle.
REQ-036 Full-length equal: A=5, B=5 -> equal=1, done 4 edges after start.
REQ-037 Signed vs unsigned: A=4'b1001, B=4'b0011.
- signed_mode=1 -> less=1, latency 1
- signed_mode=0 -> great=1, latency 1.
REQ-038 Start while busy: A=6, B=7 (latency 4); then start with A=15, B=0 on the 2nd edge -> ignored, result less=1 at edge 4. Then start again during the DONE cycle with A=2, B=2 -> accepted, equal=1 after 4 more edges.
REQ-039 Reset mid-operation: A=0, B=1; assert rst on edge 2 -> no done, all outputs 0. Next start with A=3, B=1 -> great=1 at latency 3.
